pipe_stage_skid: RTL

//   Generic pipeline stage register that replaces the fixed, always-enabled inter-stage

---
 rtl/pipe_stage_skid.sv | 83 ++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a one-entry skid buffer and synchronous flush
module pipe_stage_skid #(
    parameter int                DATA_W   = 104,
    parameter int                CTRL_W   = 3,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);
    // state bits are {m_v, s_v}; 2'b01 has no name because it must never occur
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
    state_t            state, state_nxt;
    logic              m_v, s_v, acc, drn;
    logic              m_from_in, m_from_s, s_from_in;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    assign m_v = state[1];
    assign s_v = state[0];
    assign acc = in_valid_i & in_ready_o;
    assign drn = out_valid_o & out_ready_i;
    // occupancy state; reset beats flush, flush is folded into the next-state logic
    always_ff @(posedge clk_i) begin
        state <= rst_i ? EMPTY : state_nxt;
    end
    // occupancy transitions: one beat in and one out at most per cycle
    always_comb begin
        state_nxt = flush_i          ? EMPTY :
                    (state == FULL)  ? (drn ? ONE : FULL) :
                    (state == ONE)   ? ((acc == drn) ? ONE : (acc ? FULL : EMPTY)) :
                                       (acc ? ONE : EMPTY);
    end
    // register load selects; a flushed cycle leaves the payload flops untouched
    always_comb begin
        m_from_in = acc & ~flush_i & ((state == EMPTY) | ((state == ONE) & drn));
        s_from_in = acc & ~flush_i & (state == ONE) & ~drn;
        m_from_s  = ~flush_i & (state == FULL) & drn;
    end
    // head entry: refilled from the input when it empties, or from the skid entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_data <= RST_DATA;
            m_ctrl <= '0;
        end else if (m_from_in) begin
            m_data <= in_data_i;
            m_ctrl <= in_ctrl_i;
        end else if (m_from_s) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
        end
    end
    // skid entry: catches the beat that arrives while the head is stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_data <= RST_DATA;
            s_ctrl <= '0;
        end else if (s_from_in) begin
            s_data <= in_data_i;
            s_ctrl <= in_ctrl_i;
        end
    end
    // outputs come straight from flops; ready never looks at out_ready_i
    always_comb begin
        in_ready_o  = ~s_v;
        out_valid_o = m_v;
        out_data_o  = m_data;
        out_ctrl_o  = m_ctrl & {CTRL_W{m_v}};
        count_o     = {s_v, m_v & ~s_v};
    end
    // a held skid beat without a head beat would break FIFO order
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (state != 2'b01);
    end
endmodule
